// File: rtl/tz80_bus_pkg.sv
// rtl/tz80_bus_pkg.sv - shared address map, STAT layout and read constants for the tz80 memory responder
package tz80_bus_pkg;

    localparam logic [15:0] ADDR_TXD  = 16'hFF00;
    localparam logic [15:0] ADDR_STAT = 16'hFF01;
    localparam logic [15:0] ADDR_RXD  = 16'hFF02;
    localparam logic [15:0] WPROT_TOP = 16'h0400;

    localparam int STAT_TX_FULL = 0;
    localparam int STAT_RX_FULL = 1;
    localparam int STAT_OVF     = 2;
    localparam int STAT_WPROT   = 3;

    localparam logic [7:0] UNMAPPED_RDATA = 8'hFF;
    localparam logic [7:0] TXD_RDATA      = 8'h00;

    // Assemble the STAT byte so bit positions live in one place
    function automatic logic [7:0] pack_stat(input logic tx_full, input logic rx_full,
                                             input logic ovf, input logic wprot);
        logic [7:0] s;
        s               = 8'h00;
        s[STAT_TX_FULL] = tx_full;
        s[STAT_RX_FULL] = rx_full;
        s[STAT_OVF]     = ovf;
        s[STAT_WPROT]   = wprot;
        return s;
    endfunction

endpackage

// File: rtl/tz80_byte_fifo.sv
// rtl/tz80_byte_fifo.sv - synchronous FIFO with push/pop, full/empty and occupancy count
module tz80_byte_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    // A pop on a full FIFO frees the slot the same-cycle push writes into
    always_comb begin
        do_pop  = pop && !empty;
        do_push = push && (!full || do_pop);
    end

    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign pop_data = mem[rd_ptr];

    // Storage is never reset; only the pointers define what is valid
    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/tz80_mem_responder.sv
// rtl/tz80_mem_responder.sv - tz80 bus target: RAM, TX FIFO, RX holding register; TZ80_WPROT_EN protects 0x0000-0x03FF
module tz80_mem_responder
    import tz80_bus_pkg::*;
#(
    parameter int         RAM_AW   = 14,
    parameter int         TX_DEPTH = 8,
    parameter logic [7:0] IO_PAGE  = 8'hFF
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] address,
    input  logic [7:0]  cpu_wdata,
    input  logic        cpu_we,
    output logic [7:0]  cpu_rdata,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready
);

    localparam int TX_CW = $clog2(TX_DEPTH) + 1;

    logic [7:0]       ram [2**RAM_AW];

    logic             in_ram;
    logic             is_txd;
    logic             is_stat;
    logic             is_rxd;
    logic             wprot_block;
    logic             ram_we;

    logic             tx_push;
    logic             tx_pop;
    logic             tx_fifo_full;
    logic             tx_fifo_empty;
    logic [TX_CW-1:0] tx_count;
    logic             tx_full;

    logic             rx_full;
    logic [7:0]       rx_hold;
    logic             rx_pop;
    logic             rx_accept;
    logic             prev_addr_rxd;

    logic             overflow;
    logic             wprot_err;
    logic             overflow_set;
    logic             stat_clr;
    logic [7:0]       rd_next;

    // Address decode and per-cycle strobes derived from it
    always_comb begin
        in_ram  = (address[15:RAM_AW] == '0);
        is_txd  = (address == {IO_PAGE, ADDR_TXD[7:0]});
        is_stat = (address == {IO_PAGE, ADDR_STAT[7:0]});
        is_rxd  = (address == {IO_PAGE, ADDR_RXD[7:0]});
`ifdef TZ80_WPROT_EN
        wprot_block = in_ram && (address < WPROT_TOP);
`else
        wprot_block = 1'b0;
`endif
        ram_we       = cpu_we && in_ram && !wprot_block;
        tx_push      = cpu_we && is_txd;
        tx_pop       = tx_valid && tx_ready;
        overflow_set = tx_push && tx_fifo_full && !tx_pop;
        stat_clr     = cpu_we && is_stat;
        // No read strobe exists, so only the first read cycle at RXD counts as a pop
        rx_pop       = is_rxd && !cpu_we && !prev_addr_rxd && rx_full;
        rx_accept    = rx_valid && !rx_full;
    end

    assign tx_valid = !tx_fifo_empty;
    assign tx_full  = (tx_count == TX_CW'(TX_DEPTH));
    assign rx_ready = !rx_full;

    tz80_byte_fifo #(
        .DEPTH (TX_DEPTH),
        .WIDTH (8)
    ) u_tx_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (tx_push),
        .push_data (cpu_wdata),
        .pop       (tx_pop),
        .pop_data  (tx_data),
        .full      (tx_fifo_full),
        .empty     (tx_fifo_empty),
        .count     (tx_count)
    );

    // RAM write port; contents survive reset
    always_ff @(posedge clock) begin
        if (ram_we) begin
            ram[address[RAM_AW-1:0]] <= cpu_wdata;
        end
    end

    // Read mux for the address presented this cycle; RAM side is read-first
    always_comb begin
        rd_next = UNMAPPED_RDATA;
        if (in_ram) begin
            rd_next = ram[address[RAM_AW-1:0]];
        end else if (is_txd) begin
            rd_next = TXD_RDATA;
        end else if (is_stat) begin
            rd_next = pack_stat(tx_full, rx_full, overflow, wprot_err);
        end else if (is_rxd) begin
            rd_next = rx_hold;
        end
    end

    // Registered read data: one cycle after the address is sampled
    always_ff @(posedge clock) begin
        if (reset) begin
            cpu_rdata <= 8'h00;
        end else begin
            cpu_rdata <= rd_next;
        end
    end

    // RX holding register and the previous-cycle RXD read flag
    always_ff @(posedge clock) begin
        if (reset) begin
            rx_full       <= 1'b0;
            rx_hold       <= 8'h00;
            prev_addr_rxd <= 1'b0;
        end else begin
            prev_addr_rxd <= is_rxd && !cpu_we;
            if (rx_pop) begin
                rx_full <= 1'b0;
            end else if (rx_accept) begin
                rx_full <= 1'b1;
                rx_hold <= rx_data;
            end
        end
    end

    // Sticky error bits, cleared by any write to STAT
    always_ff @(posedge clock) begin
        if (reset) begin
            overflow  <= 1'b0;
            wprot_err <= 1'b0;
        end else if (stat_clr) begin
            overflow  <= 1'b0;
            wprot_err <= 1'b0;
        end else begin
            if (overflow_set) begin
                overflow <= 1'b1;
            end
            if (cpu_we && wprot_block) begin
                wprot_err <= 1'b1;
            end
        end
    end

endmodule
